// File: rtl/sirv_irq_cond_if.sv
// ICB slave-port bundle for the interrupt conditioner register file.
// The master drives commands and response acceptance; the slave answers.
interface sirv_irq_cond_if;
    logic        i_icb_cmd_valid;
    logic        i_icb_cmd_ready;
    logic [11:0] i_icb_cmd_addr;
    logic        i_icb_cmd_read;
    logic [31:0] i_icb_cmd_wdata;
    logic        i_icb_rsp_valid;
    logic        i_icb_rsp_ready;
    logic [31:0] i_icb_rsp_rdata;

    modport master (
        output i_icb_cmd_valid, i_icb_cmd_addr, i_icb_cmd_read, i_icb_cmd_wdata,
        output i_icb_rsp_ready,
        input  i_icb_cmd_ready, i_icb_rsp_valid, i_icb_rsp_rdata
    );

    modport slave (
        input  i_icb_cmd_valid, i_icb_cmd_addr, i_icb_cmd_read, i_icb_cmd_wdata,
        input  i_icb_rsp_ready,
        output i_icb_cmd_ready, i_icb_rsp_valid, i_icb_rsp_rdata
    );
endinterface

// File: rtl/sirv_irq_cond.sv
// Interrupt conditioner ahead of the PLIC: synchronises raw lines, applies polarity,
// and presents level or latched-edge requests, with an ICB register file for control.
module sirv_irq_cond #(
    parameter int IRQ_NUM     = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    sirv_irq_cond_if.slave     icb,
    input  logic [IRQ_NUM-1:0] irq_raw_i,
    output logic [IRQ_NUM-1:0] irq_o
);

    logic [IRQ_NUM-1:0] sync_q [SYNC_STAGES];
    logic [IRQ_NUM-1:0] mode_q, pol_q, pend_q, prev_q;
    logic [IRQ_NUM-1:0] mode_next, pol_next, pend_next;
    logic [IRQ_NUM-1:0] s, a, rise, wbits;
    logic               accept, wr, mapped;
    logic               wr_mode, wr_pol, wr_pend;
    logic               rsp_valid_q;
    logic [31:0]        rsp_rdata_q;
    logic               unused_ok;

    function automatic logic [31:0] read_word(
        input logic [11:0]        addr,
        input logic [IRQ_NUM-1:0] mode,
        input logic [IRQ_NUM-1:0] pol,
        input logic [IRQ_NUM-1:0] pend,
        input logic [IRQ_NUM-1:0] raw
    );
        logic [31:0] r;
        r = '0;
        if (addr[11:4] == 8'd0) begin
            unique case (addr[3:2])
                2'd0: r[IRQ_NUM-1:0] = mode;
                2'd1: r[IRQ_NUM-1:0] = pol;
                2'd2: r[IRQ_NUM-1:0] = pend & mode;
                2'd3: r[IRQ_NUM-1:0] = raw;
                default: r = '0;
            endcase
        end
        return r;
    endfunction

    assign unused_ok = ^{icb.i_icb_cmd_addr[1:0], icb.i_icb_cmd_wdata};

    // Synchroniser chain for the asynchronous raw lines
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= irq_raw_i;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign s    = sync_q[SYNC_STAGES-1];
    assign a    = s ^ pol_q;
    assign rise = a & ~prev_q;

    assign icb.i_icb_cmd_ready = ~rsp_valid_q | icb.i_icb_rsp_ready;
    assign icb.i_icb_rsp_valid = rsp_valid_q;
    assign icb.i_icb_rsp_rdata = rsp_rdata_q;

    assign accept  = icb.i_icb_cmd_valid & icb.i_icb_cmd_ready;
    assign wr      = accept & ~icb.i_icb_cmd_read;
    assign mapped  = (icb.i_icb_cmd_addr[11:4] == 8'd0);
    assign wr_mode = wr & mapped & (icb.i_icb_cmd_addr[3:2] == 2'd0);
    assign wr_pol  = wr & mapped & (icb.i_icb_cmd_addr[3:2] == 2'd1);
    assign wr_pend = wr & mapped & (icb.i_icb_cmd_addr[3:2] == 2'd2);
    assign wbits   = icb.i_icb_cmd_wdata[IRQ_NUM-1:0];

    // Register next-state: a mode flip discards stale pend bits; a new edge beats W1C
    always_comb begin
        mode_next = mode_q;
        pol_next  = pol_q;
        if (wr_mode) mode_next = wbits;
        if (wr_pol)  pol_next  = wbits;
        pend_next = pend_q & ~(mode_q ^ mode_next);
        if (wr_pend) pend_next = pend_next & ~wbits;
        pend_next = pend_next | (rise & mode_next);
    end

    // Control/state registers and conditioned output
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mode_q <= '0;
            pol_q  <= '0;
            pend_q <= '0;
            prev_q <= '0;
            irq_o  <= '0;
        end else begin
            mode_q <= mode_next;
            pol_q  <= pol_next;
            pend_q <= pend_next;
            // Using the new polarity keeps an inversion change from looking like an edge
            prev_q <= s ^ pol_next;
            irq_o  <= (mode_q & pend_q) | (~mode_q & a);
        end
    end

    // Response stage: one registered beat per accepted command, held until taken
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else if (accept) begin
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= icb.i_icb_cmd_read
                           ? read_word(icb.i_icb_cmd_addr, mode_q, pol_q, pend_q, s)
                           : 32'd0;
        end else if (icb.i_icb_rsp_ready) begin
            rsp_valid_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sirv_irq_cond.sv
// Directed bench for sirv_irq_cond: sync latency, edge latching, W1C races,
// polarity changes, ICB back-pressure and mid-transaction reset.
module tb_sirv_irq_cond;
    logic        clk;
    logic        rst_n;
    logic [31:0] raw;
    logic [31:0] irq;
    logic [31:0] rd;
    int          vec  = 0;
    int          errs = 0;

    sirv_irq_cond_if bus ();

    sirv_irq_cond #(.IRQ_NUM(32), .SYNC_STAGES(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .icb       (bus),
        .irq_raw_i (raw),
        .irq_o     (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec++;
        assert (obs === exp) else begin
            errs++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
            $error("miscompare at %s", tag);
        end
    endtask

    task automatic icb(input logic rd_op, input logic [11:0] addr,
                       input logic [31:0] wd, output logic [31:0] rdata);
        int n;
        n = 0;
        bus.i_icb_cmd_valid = 1'b1;
        bus.i_icb_cmd_read  = rd_op;
        bus.i_icb_cmd_addr  = addr;
        bus.i_icb_cmd_wdata = wd;
        while (!bus.i_icb_cmd_ready && n < 20) begin
            step();
            n++;
        end
        step();
        bus.i_icb_cmd_valid = 1'b0;
        chk("cmd_ready_wait", 32'(n >= 20), 32'd0);
        chk("rsp_valid", {31'd0, bus.i_icb_rsp_valid}, 32'd1);
        rdata = bus.i_icb_rsp_rdata;
    endtask

    task automatic wr(input logic [11:0] addr, input logic [31:0] wd);
        logic [31:0] dummy;
        icb(1'b0, addr, wd, dummy);
    endtask

    task automatic rd_chk(input string tag, input logic [11:0] addr, input logic [31:0] exp);
        logic [31:0] v;
        icb(1'b1, addr, 32'd0, v);
        chk(tag, v, exp);
    endtask

    initial begin
        bus.i_icb_cmd_valid = 1'b0;
        bus.i_icb_cmd_read  = 1'b0;
        bus.i_icb_cmd_addr  = '0;
        bus.i_icb_cmd_wdata = '0;
        bus.i_icb_rsp_ready = 1'b1;
        rst_n = 1'b0;
        raw   = 32'hFFFF_FFFF;

        // 1: reset state and raw->irq latency of SYNC_STAGES+1
        repeat (3) step();
        chk("rst_irq", irq, 32'd0);
        chk("rst_rsp_valid", {31'd0, bus.i_icb_rsp_valid}, 32'd0);
        chk("rst_rsp_rdata", bus.i_icb_rsp_rdata, 32'd0);
        rst_n = 1'b1;
        step();
        chk("lat_cyc1", irq, 32'd0);
        step();
        chk("lat_cyc2", irq, 32'd0);
        step();
        chk("lat_cyc3", irq, 32'hFFFF_FFFF);
        raw = 32'd0;
        repeat (4) step();
        chk("level_low", irq, 32'd0);

        // 2: edge mode latch and W1C
        wr(12'h000, 32'h1);
        raw = 32'h1;
        step();
        raw = 32'h0;
        repeat (5) step();
        chk("edge_latched", irq, 32'h1);
        rd_chk("pend_rd1", 12'h008, 32'h1);
        repeat (3) step();
        chk("edge_held", irq, 32'h1);
        wr(12'h008, 32'h1);
        step();
        chk("w1c_irq", irq, 32'h0);
        rd_chk("pend_rd_cleared", 12'h008, 32'h0);

        // 3: new edge in the same cycle as W1C keeps PEND set
        raw = 32'h1;
        step();
        raw = 32'h0;
        repeat (5) step();
        chk("edge2_latched", irq, 32'h1);
        raw = 32'h1;
        step();
        step();
        bus.i_icb_cmd_valid = 1'b1;
        bus.i_icb_cmd_read  = 1'b0;
        bus.i_icb_cmd_addr  = 12'h008;
        bus.i_icb_cmd_wdata = 32'h1;
        step();
        bus.i_icb_cmd_valid = 1'b0;
        raw = 32'h0;
        chk("race_rsp_valid", {31'd0, bus.i_icb_rsp_valid}, 32'd1);
        step();
        chk("race_irq", irq, 32'h1);
        rd_chk("race_pend", 12'h008, 32'h1);
        wr(12'h008, 32'h1);
        wr(12'h000, 32'h0);

        // 4: polarity inversion, level and edge
        wr(12'h004, 32'h20);
        step();
        chk("pol_level_irq", irq, 32'h20);
        rd_chk("pol_rd", 12'h004, 32'h20);
        wr(12'h004, 32'h0);
        repeat (2) step();
        chk("pol_restore_irq", irq, 32'h0);
        wr(12'h000, 32'h20);
        wr(12'h004, 32'h20);
        repeat (3) step();
        rd_chk("pol_no_spurious", 12'h008, 32'h0);
        chk("pol_no_spurious_irq", irq, 32'h0);
        wr(12'h000, 32'h0);
        wr(12'h004, 32'h0);

        // 5: ICB back-pressure, unmapped space, back-to-back reads
        raw = 32'hA5;
        repeat (4) step();
        wr(12'h000, 32'h11);
        wr(12'h004, 32'h100);
        repeat (3) step();
        bus.i_icb_rsp_ready = 1'b0;
        bus.i_icb_cmd_valid = 1'b1;
        bus.i_icb_cmd_read  = 1'b1;
        bus.i_icb_cmd_addr  = 12'h00C;
        step();
        bus.i_icb_cmd_valid = 1'b0;
        chk("bp_rsp_valid1", {31'd0, bus.i_icb_rsp_valid}, 32'd1);
        chk("bp_rdata1", bus.i_icb_rsp_rdata, 32'hA5);
        chk("bp_cmd_ready1", {31'd0, bus.i_icb_cmd_ready}, 32'd0);
        step();
        chk("bp_rsp_valid2", {31'd0, bus.i_icb_rsp_valid}, 32'd1);
        chk("bp_rdata2", bus.i_icb_rsp_rdata, 32'hA5);
        chk("bp_cmd_ready2", {31'd0, bus.i_icb_cmd_ready}, 32'd0);
        bus.i_icb_rsp_ready = 1'b1;
        #1;
        chk("bp_cmd_ready3", {31'd0, bus.i_icb_cmd_ready}, 32'd1);
        step();
        chk("bp_rsp_done", {31'd0, bus.i_icb_rsp_valid}, 32'd0);
        rd_chk("unmapped_rd", 12'h010, 32'h0);
        wr(12'h010, 32'hFFFF_FFFF);
        rd_chk("unmapped_wr_ignored", 12'h000, 32'h11);

        bus.i_icb_cmd_valid = 1'b1;
        bus.i_icb_cmd_read  = 1'b1;
        bus.i_icb_cmd_addr  = 12'h000;
        step();
        chk("b2b_rd0", bus.i_icb_rsp_rdata, 32'h11);
        bus.i_icb_cmd_addr  = 12'h004;
        step();
        chk("b2b_rd1", bus.i_icb_rsp_rdata, 32'h100);
        bus.i_icb_cmd_addr  = 12'h008;
        step();
        chk("b2b_rd2", bus.i_icb_rsp_rdata, 32'h0);
        bus.i_icb_cmd_addr  = 12'h00C;
        step();
        chk("b2b_rd3", bus.i_icb_rsp_rdata, 32'hA5);
        chk("b2b_valid4", {31'd0, bus.i_icb_rsp_valid}, 32'd1);
        bus.i_icb_cmd_valid = 1'b0;
        step();
        chk("b2b_done5", {31'd0, bus.i_icb_rsp_valid}, 32'd0);

        // 6: reset while a response is outstanding and PEND=0xF
        raw = 32'h0;
        repeat (4) step();
        wr(12'h000, 32'hF);
        wr(12'h004, 32'h0);
        raw = 32'hF;
        repeat (5) step();
        rd_chk("pend_f", 12'h008, 32'hF);
        chk("pend_f_irq", irq, 32'hF);
        bus.i_icb_rsp_ready = 1'b0;
        bus.i_icb_cmd_valid = 1'b1;
        bus.i_icb_cmd_read  = 1'b1;
        bus.i_icb_cmd_addr  = 12'h008;
        step();
        bus.i_icb_cmd_valid = 1'b0;
        chk("pre_rst_rsp_valid", {31'd0, bus.i_icb_rsp_valid}, 32'd1);
        rst_n = 1'b0;
        step();
        chk("midrst_rsp_valid", {31'd0, bus.i_icb_rsp_valid}, 32'd0);
        chk("midrst_rsp_rdata", bus.i_icb_rsp_rdata, 32'd0);
        chk("midrst_irq", irq, 32'd0);
        rst_n = 1'b1;
        bus.i_icb_rsp_ready = 1'b1;
        raw = 32'h0;
        step();
        rd_chk("midrst_mode", 12'h000, 32'h0);
        wr(12'h000, 32'hF);
        rd_chk("midrst_pend", 12'h008, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end
endmodule
